platform_spawner: RTL and testbench
===================================

# platform_spawner

Keeps the on-screen platform table for the Doodle Jump game: scrolls every platform down by the per-frame camera offset, retires platforms that fall below the screen, and respawns each one above the current topmost platform. Respawn positions come from the 9-bit LFSR output. The block sits directly downstream of the LFSR and upstream of the platform sprite renderer and collision logic, which read its registered position outputs.

## Interface
Parameters
- NUM_PLAT, 8: number of platform slots.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels. A platform with y >= SCREEN_H is off-screen.
- PLAT_W, 64: platform width. SCREEN_W - PLAT_W must be >= 511.
- MIN_GAP, 40: minimum vertical gap between consecutive spawns.

Ports
- Clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse once per video frame.
- scroll_dy  in  9  unsigned downward scroll for this frame; sampled on an accepted frame_start.
- rand_val  in  9  LFSR output value.
- rand_valid  in  1  LFSR seed_out level. Only its rising edge marks a fresh value.
- plat_x  out  NUM_PLAT*10  packed unsigned x of the left edge; slot i occupies bits [i*10 +: 10].
- plat_y  out  NUM_PLAT*11  packed signed y of the top edge; slot i occupies bits [i*11 +: 11]. Negative means above the screen.
- busy  out  1  high in every state except IDLE.
- update_done  out  1  one-cycle pulse when a frame update completes.

## Operation
- Reset values, asynchronous, for slot i:
  - x[i] = i*64
  - y[i] = 440 - i*60 (440, 380, ..., 20)
  - top_y = 20; state = IDLE; busy = 0; update_done = 0; the rand edge-detect register = 0
- State machine: IDLE -> SCROLL -> CHECK -> (WAIT_RAND -> SPAWN -> CHECK)* -> DONE -> IDLE.
- IDLE: on frame_start, latch scroll_dy into dy_r, clear index k, and go to SCROLL. frame_start in any other state is ignored and dropped.
- SCROLL (1 cycle):
  - every y[i] += dy_r and top_y += dy_r
  - use 11-bit signed arithmetic with dy_r zero-extended; no overflow is possible (max 479 + 511 = 990)
- CHECK (1 cycle per slot):
  - if y[k] >= SCREEN_H (signed compare), go to WAIT_RAND
  - otherwise, if k == NUM_PLAT-1 go to DONE, else increment k
- WAIT_RAND: hold until a rising edge of rand_valid (rand_valid high now, low in the previous cycle), then go to SPAWN. A level that is already high on entry does not count.
- SPAWN (1 cycle), using rand_val sampled on the edge cycle:
  - x[k] = {1'b0, rand_val}
  - y[k] = top_y - (MIN_GAP + rand_val[4:0])
  - top_y = the new y[k]
  - then go back to CHECK with k unchanged; that CHECK re-evaluates slot k, finds it on-screen, and advances
- DONE (1 cycle): update_done = 1, then go to IDLE.
- A spawned y may be negative; the renderer clips it. The gap range is 40..71, and the lowest reachable y is -512 + margin, which is never hit in play.
- Slots are processed in index order. Several spawns in one frame chain upward through top_y.

## Timing
- All outputs are registered. plat_x and plat_y change only in the SCROLL and SPAWN cycles.
- With frame_start accepted in cycle t and no spawns: SCROLL at t+1, CHECK at t+2..t+NUM_PLAT+1, DONE (update_done) at t+NUM_PLAT+2, IDLE at t+NUM_PLAT+3. busy is high from t+1 through t+NUM_PLAT+2.
- Each spawn adds WAIT_RAND (1..16 cycles with the LFSR 16-cycle period) + SPAWN (1) + the extra CHECK (1).
- Worst case (all 8 slots spawn): under 160 cycles, far inside one frame.
- Reset_n assertion at any point, including mid-WAIT_RAND, forces the reset layout in the same cycle with no pulse on update_done.

## Structure
- Package platform_pkg holds NUM_PLAT, SCREEN_W, SCREEN_H, PLAT_W and MIN_GAP defaults, typedef plat_t (x logic [9:0], y logic signed [10:0]), and the state enum spawn_state_t {IDLE, SCROLL, CHECK, WAIT_RAND, SPAWN, DONE}.
- Sub-module rise_detect (Clk, Reset_n, d, pulse) produces the rand_valid edge; reused by other stages.
- The slot array is an unpacked plat_t array, flattened onto the packed output ports.

## Test plan
- Reset -> y = 440,380,...,20; x = 0,64,...,448; busy = 0.
- frame_start with scroll_dy = 0 at t -> no position change; update_done high only at t+10; busy high t+1..t+10.
- scroll_dy = 40, rand_val = 0x12C on the next rand_valid rise -> slot0 y goes 440 to 480 and is respawned at x = 300, y = 60 - 52 = 8; slots 1..7 y = 420..60; top_y = 8.
- Continue with scroll_dy = 40, rand_val = 0x1FF -> slot1 (420 to 460) stays; nothing reaches 480; no spawn and no rand wait. Then scroll_dy = 20 -> slot1 (460 to 480) respawns at x = 511, y = 68 - 71 = -3.
- frame_start while busy (during WAIT_RAND) -> ignored; exactly one update_done per accepted frame.
- Reset_n low during WAIT_RAND with rand_valid held high -> layout resets immediately, busy = 0; after release, a held-high rand_valid triggers no spawn.

Source files
------------

// File: rtl/platform_pkg.sv
// rtl/platform_pkg.sv - shared types and default geometry for the platform spawner
//
// Purpose: default geometry parameters, reset-layout constants, the per-slot
// platform record and the spawner state encoding.
// Ports: none (package).

package platform_pkg;

  localparam int NUM_PLAT_DEF = 8;
  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;
  localparam int PLAT_W_DEF   = 64;
  localparam int MIN_GAP_DEF  = 40;

  localparam int XW = 10;  // x coordinate width (unsigned)
  localparam int YW = 11;  // y coordinate width (signed, negative = above screen)
  localparam int RW = 9;   // LFSR / scroll value width

  // Reset layout: evenly spaced staircase from the bottom of the screen upward.
  localparam int RESET_X_STEP = 64;
  localparam int RESET_Y0     = 440;
  localparam int RESET_Y_STEP = 60;

  typedef struct packed {
    logic        [XW-1:0] x;
    logic signed [YW-1:0] y;
  } plat_t;

  typedef enum logic [2:0] {
    IDLE,
    SCROLL,
    CHECK,
    WAIT_RAND,
    SPAWN,
    DONE
  } spawn_state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - single-cycle rising-edge detector for a level input
//
// Purpose: pulse is high in the cycle where d is high and was low the cycle
// before. A level already high out of reset produces one pulse.
// Ports:
//   Clk      in   clock
//   Reset_n  in   asynchronous active-low reset (history cleared to 0)
//   d        in   level input
//   pulse    out  rising-edge strobe

module rise_detect (
  input  logic Clk,
  input  logic Reset_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/platform_spawner.sv
// rtl/platform_spawner.sv - scrolls, retires and respawns the on-screen platform table
//
// Purpose: once per accepted frame, scroll all platforms down by scroll_dy,
// then walk the slots in index order; any slot that has fallen off the bottom
// is respawned above the current topmost platform using a fresh LFSR value.
// Ports:
//   Clk          in   system clock
//   Reset_n      in   asynchronous active-low reset
//   frame_start  in   per-frame pulse, accepted only while idle
//   scroll_dy    in   [8:0]  downward scroll, latched on acceptance
//   rand_val     in   [8:0]  LFSR value, sampled on a rand_valid rising edge
//   rand_valid   in   LFSR value-ready level
//   plat_x       out  [NUM_PLAT*10-1:0] packed slot x (slot i at [i*10 +: 10])
//   plat_y       out  [NUM_PLAT*11-1:0] packed signed slot y (slot i at [i*11 +: 11])
//   busy         out  high outside IDLE
//   update_done  out  one-cycle pulse at the end of a frame update

module platform_spawner
  import platform_pkg::*;
#(
  parameter int NUM_PLAT = NUM_PLAT_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int PLAT_W   = PLAT_W_DEF,
  parameter int MIN_GAP  = MIN_GAP_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_start,
  input  logic [RW-1:0]          scroll_dy,
  input  logic [RW-1:0]          rand_val,
  input  logic                   rand_valid,
  output logic [NUM_PLAT*XW-1:0] plat_x,
  output logic [NUM_PLAT*YW-1:0] plat_y,
  output logic                   busy,
  output logic                   update_done
);

  localparam int KW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam logic        [KW-1:0] K_LAST    = KW'(NUM_PLAT - 1);
  localparam logic signed [YW-1:0] Y_LIMIT   = YW'(SCREEN_H);
  localparam logic signed [YW-1:0] TOP_RESET = YW'(RESET_Y0 - (NUM_PLAT - 1) * RESET_Y_STEP);

  // A full 9-bit random x must always leave the platform inside the screen.
  if (SCREEN_W - PLAT_W < 511) begin : g_x_range_check
    $error("platform_spawner: SCREEN_W - PLAT_W must be at least 511");
  end

  spawn_state_t         state, state_nxt;
  plat_t                slots [NUM_PLAT];
  logic signed [YW-1:0] top_y;
  logic        [RW-1:0] dy_r;
  logic        [RW-1:0] rand_r;
  logic        [KW-1:0] k;
  logic                 rand_rise;
  logic                 slot_off;
  logic signed [YW-1:0] spawn_y;

  logic do_start, do_scroll, do_adv, do_capture, do_spawn;

  rise_detect u_rand_rise (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .d       (rand_valid),
    .pulse   (rand_rise)
  );

  // Signed compare so slots parked above the screen (negative y) stay live.
  assign slot_off = (slots[k].y >= Y_LIMIT);

  // New slot sits MIN_GAP..MIN_GAP+31 above the current topmost platform.
  assign spawn_y = top_y - YW'(MIN_GAP) - {{(YW-5){1'b0}}, rand_r[4:0]};

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (frame_start) state_nxt = SCROLL;
      SCROLL:    state_nxt = CHECK;
      CHECK: begin
        if (slot_off)         state_nxt = WAIT_RAND;
        else if (k == K_LAST) state_nxt = DONE;
        else                  state_nxt = CHECK;
      end
      WAIT_RAND: if (rand_rise) state_nxt = SPAWN;
      SPAWN:     state_nxt = CHECK;  // re-check slot k, which is now on-screen
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output and datapath-control decode
  always_comb begin
    busy        = (state != IDLE);
    update_done = (state == DONE);
    do_start    = (state == IDLE) && frame_start;
    do_scroll   = (state == SCROLL);
    do_adv      = (state == CHECK) && !slot_off && (k != K_LAST);
    do_capture  = (state == WAIT_RAND) && rand_rise;
    do_spawn    = (state == SPAWN);
  end

  // Slot table and frame working registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_PLAT; i++) begin
        slots[i].x <= XW'(i * RESET_X_STEP);
        slots[i].y <= YW'(RESET_Y0 - i * RESET_Y_STEP);
      end
      top_y  <= TOP_RESET;
      dy_r   <= '0;
      rand_r <= '0;
      k      <= '0;
    end else begin
      if (do_start) begin
        dy_r <= scroll_dy;
        k    <= '0;
      end
      if (do_scroll) begin
        for (int i = 0; i < NUM_PLAT; i++) begin
          slots[i].y <= slots[i].y + $signed({2'b00, dy_r});
        end
        top_y <= top_y + $signed({2'b00, dy_r});
      end
      if (do_adv) begin
        k <= k + KW'(1);
      end
      if (do_capture) begin
        rand_r <= rand_val;
      end
      if (do_spawn) begin
        slots[k].x <= {1'b0, rand_r};
        slots[k].y <= spawn_y;
        top_y      <= spawn_y;
      end
    end
  end

  for (genvar i = 0; i < NUM_PLAT; i++) begin : g_flat
    assign plat_x[i*XW +: XW] = slots[i].x;
    assign plat_y[i*YW +: YW] = slots[i].y;
  end

endmodule

// File: tb/tb_platform_spawner.sv
// tb/tb_platform_spawner.sv - self-checking bench for platform_spawner

module tb_platform_spawner;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [8:0]  scroll_dy = '0;
  logic [8:0]  rand_val = '0;
  logic        rand_valid = 1'b0;
  logic [79:0] plat_x;
  logic [87:0] plat_y;
  logic        busy;
  logic        update_done;

  int errors = 0;
  int checks = 0;
  bit rnd_en = 1'b0;

  // Reference table: what the screen should look like, in plain integers.
  int mx [8];
  int my [8];
  int mtop;

  typedef struct packed {
    logic [8:0]        dy;
    logic [8:0]        r;
    logic [7:0]        lat;  // 0 = latency not fixed for this vector
    logic [0:7][9:0]   x;
    logic [0:7][10:0]  y;
  } vec_t;

  vec_t tbl [4];

  platform_spawner dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_start (frame_start),
    .scroll_dy   (scroll_dy),
    .rand_val    (rand_val),
    .rand_valid  (rand_valid),
    .plat_x      (plat_x),
    .plat_y      (plat_y),
    .busy        (busy),
    .update_done (update_done)
  );

  always #5 Clk = ~Clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int gx(input int i);
    return int'(plat_x[i*10 +: 10]);
  endfunction

  function automatic int gy(input int i);
    return int'($signed(plat_y[i*11 +: 11]));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    if (rnd_en) rand_valid = 1'($urandom_range(0, 1));
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      mx[i] = i * 64;
      my[i] = 440 - i * 60;
    end
    mtop = 20;
  endfunction

  // One frame from the rules: scroll everything, then respawn fallen slots in order.
  function automatic int model_frame(input int dy, input int r);
    int ns = 0;
    for (int i = 0; i < 8; i++) my[i] += dy;
    mtop += dy;
    for (int i = 0; i < 8; i++) begin
      if (my[i] >= 480) begin
        mx[i] = r;
        my[i] = mtop - (40 + (r % 32));
        mtop  = my[i];
        ns++;
      end
    end
    return ns;
  endfunction

  task automatic check_model(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s x%0d", tag, i), gx(i), mx[i]);
      chk($sformatf("%s y%0d", tag, i), gy(i), my[i]);
    end
  endtask

  task automatic apply_reset();
    Reset_n = 1'b0;
    frame_start = 1'b0;
    tick();
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!update_done && n < 200) begin
      tick();
      n++;
    end
    chk(name, int'(update_done), 1);
  endtask

  // Issues one frame and returns the cycle (relative to acceptance) of update_done.
  task automatic run_frame(input logic [8:0] dy, input logic [8:0] r,
                           input bit inject, output int lat);
    int n;
    int busy_low;
    int extra;
    scroll_dy   = dy;
    rand_val    = r;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    scroll_dy   = 9'($urandom);  // must have been latched already
    n = 1;
    busy_low = 0;
    while (!update_done && n < 400) begin
      if (!busy) busy_low++;
      if (inject && n == 3) begin
        frame_start = 1'b1;
        scroll_dy   = 9'($urandom);
      end
      tick();
      frame_start = 1'b0;
      n++;
    end
    if (!busy) busy_low++;
    chk("frame done", int'(update_done), 1);
    chk("busy during frame", busy_low, 0);
    lat = n;
    tick();
    chk("done pulse width", int'(update_done), 0);
    chk("idle after done", int'(busy), 0);
    if (inject) begin
      extra = 0;
      repeat (15) begin
        tick();
        if (update_done) extra++;
      end
      chk("ignored frame_start", extra, 0);
    end
  endtask

  initial begin
    int lat;
    int ns;
    int extra;
    int dy;
    int r;
    bit inj;

    tbl[0] = '{9'd0,   9'h055, 8'd10,
               {10'd0, 10'd64, 10'd128, 10'd192, 10'd256, 10'd320, 10'd384, 10'd448},
               {11'd440, 11'd380, 11'd320, 11'd260, 11'd200, 11'd140, 11'd80, 11'd20}};
    tbl[1] = '{9'd40,  9'h12C, 8'd0,
               {10'd300, 10'd64, 10'd128, 10'd192, 10'd256, 10'd320, 10'd384, 10'd448},
               {11'd8, 11'd420, 11'd360, 11'd300, 11'd240, 11'd180, 11'd120, 11'd60}};
    tbl[2] = '{9'd40,  9'h1FF, 8'd10,
               {10'd300, 10'd64, 10'd128, 10'd192, 10'd256, 10'd320, 10'd384, 10'd448},
               {11'd48, 11'd460, 11'd400, 11'd340, 11'd280, 11'd220, 11'd160, 11'd100}};
    tbl[3] = '{9'd20,  9'h1FF, 8'd0,
               {10'd300, 10'd511, 10'd128, 10'd192, 10'd256, 10'd320, 10'd384, 10'd448},
               {11'd68, -11'sd3, 11'd420, 11'd360, 11'd300, 11'd240, 11'd180, 11'd120}};

    // Reset layout
    Reset_n = 1'b0;
    repeat (3) tick();
    model_reset();
    check_model("reset");
    chk("reset busy", int'(busy), 0);
    chk("reset update_done", int'(update_done), 0);
    Reset_n = 1'b1;
    tick();

    // Table-driven frames from the reset layout
    rnd_en = 1'b1;
    for (int j = 0; j < 4; j++) begin
      run_frame(tbl[j].dy, tbl[j].r, 1'b0, lat);
      for (int i = 0; i < 8; i++) begin
        mx[i] = int'(tbl[j].x[i]);
        my[i] = int'($signed(tbl[j].y[i]));
      end
      check_model($sformatf("vec%0d", j));
      if (tbl[j].lat != 0) chk($sformatf("vec%0d latency", j), lat, int'(tbl[j].lat));
    end

    // Held-high rand_valid does not count; frame_start in WAIT_RAND is dropped;
    // rand_val is taken from the edge cycle only.
    rnd_en = 1'b0;
    apply_reset();
    rand_valid  = 1'b1;
    rand_val    = 9'h0AA;
    scroll_dy   = 9'd40;
    frame_start = 1'b1;
    tick();                      // t+1 SCROLL
    frame_start = 1'b0;
    repeat (2) tick();           // t+3 WAIT_RAND
    frame_start = 1'b1;
    scroll_dy   = 9'd200;
    tick();
    frame_start = 1'b0;
    repeat (5) tick();           // t+9
    chk("held level busy", int'(busy), 1);
    chk("held level x0", gx(0), 0);
    chk("held level y0", gy(0), 480);
    rand_valid = 1'b0;
    tick();
    rand_valid = 1'b1;
    rand_val   = 9'h12C;
    tick();
    rand_val   = 9'h0AA;
    wait_done("edge frame done");
    model_reset();
    ns = model_frame(40, 'h12C);
    check_model("edge");
    chk("edge spawn count", ns, 1);
    extra = 0;
    repeat (15) begin
      tick();
      if (update_done) extra++;
    end
    chk("single done per frame", extra, 0);

    // Reset in the middle of WAIT_RAND with rand_valid held high
    apply_reset();
    rand_valid  = 1'b1;
    scroll_dy   = 9'd40;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (4) tick();           // t+5 WAIT_RAND
    chk("pre-reset busy", int'(busy), 1);
    Reset_n = 1'b0;
    #1;
    model_reset();
    check_model("async reset");
    chk("async reset busy", int'(busy), 0);
    chk("async reset done", int'(update_done), 0);
    tick();
    Reset_n = 1'b1;
    extra = 0;
    repeat (20) begin
      tick();
      if (update_done || busy) extra++;
    end
    chk("quiet after release", extra, 0);
    check_model("after release");

    // Randomized frames against the reference table
    apply_reset();
    model_reset();
    rnd_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      dy  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 120));
      r   = int'($urandom_range(0, 511));
      inj = ($urandom_range(0, 3) == 0);
      run_frame(9'(dy), 9'(r), inj, lat);
      ns = model_frame(dy, r);
      check_model($sformatf("rnd%0d", f));
      if (ns == 0) chk($sformatf("rnd%0d latency", f), lat, 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
